traffic_light_monitor: RTL and testbench
========================================

Name: traffic_light_monitor

Overview:
- Passive receiver for the light/walk outputs of the intersection controller.
- Samples the NS/EW light codes and walk signals every cycle.
- Tracks a per-direction light state machine with dwell timers, and flags encoding, conflict, sequencing, timing and walk-safety violations.
- Reports violations as a one-cycle error pulse with a code, sticky flags and a saturating error count; used in simulation benches and as on-chip safety supervision.

Parameters:
- MIN_YELLOW, 3, minimum number of consecutive cycles yellow must be sampled before red.
- MIN_ALL_RED, 2, minimum consecutive both-red cycles before either direction may go green.
- CNT_W, 8, width of dwell and all-red counters (saturating).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- lights_ns  in  3  NS light {RED,YELLOW,GREEN}, one-hot expected
- lights_ew  in  3  EW light {RED,YELLOW,GREEN}, one-hot expected
- walk_ns  in  1  NS walk signal
- walk_ew  in  1  EW walk signal
- clear_err  in  1  clears err_sticky and err_count
- err_valid  out  1  one-cycle pulse: violation detected in previous sample
- err_code  out  3  code of highest-priority violation (valid with err_valid)
- err_sticky  out  6  bit (n-1) set when code n ever seen since reset/clear
- err_count  out  16  saturating count of err_valid pulses
- yellow_len_ns  out  CNT_W  length of last completed NS yellow phase
- yellow_len_ew  out  CNT_W  length of last completed EW yellow phase

Behaviour:
- One clock; reset is synchronous and active-low on rst_n, sampled at posedge clk.
- Reset values:
  - all outputs 0
  - both direction trackers in D_RED with dwell 0
  - all-red counter preset to MIN_ALL_RED, so green on the first sample after reset is legal.
- Per-direction tracker states:
  - D_RED (100), D_YELLOW (010), D_GREEN (001), D_INVALID (any other code)
  - state updates every cycle to the decoded current input
  - dwell counter resets to 1 on state change, else increments; saturates at 2^CNT_W-1.
- All-red counter: increments while both inputs are exactly 100, else 0; saturates.
- Checks are evaluated each cycle on current inputs vs registered tracker state. The result is registered, giving a latency of 1: the violation is sampled at edge k and err_valid is high during the cycle after edge k.
- Error codes (lowest number has priority for err_code):
  - 1 ENC: either light code not one-hot.
  - 2 CONFLICT: both directions have GREEN or YELLOW bit set.
  - 3 SEQ: GREEN->RED, YELLOW->GREEN or RED->YELLOW. Transitions into or out of D_INVALID are not SEQ errors.
  - 4 YEL_SHORT: YELLOW->RED with yellow dwell < MIN_YELLOW.
  - 5 CLEARANCE: RED->GREEN while the registered all-red count < MIN_ALL_RED.
  - 6 WALK: walk_x high while lights_x != 001, or while the other direction != 100.
- Multiple codes in one cycle: err_code takes the lowest; every matching sticky bit is set; err_count increments by 1.
- yellow_len_x updates on every YELLOW->RED or YELLOW->other exit with the final yellow dwell, whether or not a violation occurred.
- clear_err zeroes err_sticky and err_count on the next edge. If an error is registered on the same edge, the new error's sticky bit is set and the count becomes 1 (new error wins).
- err_count saturates at 16'hFFFF and does not wrap.
- Dwell saturation does not disable checks: a saturated yellow dwell counts as >= MIN_YELLOW.
- Reset asserted mid-phase restores the reset values on the next edge; no error is flagged for the discontinuity.

Test Plan:
- Legal cycle: NS 001 x10 -> 010 x3 -> 100, both red x2 -> EW 001 -> no err_valid; yellow_len_ns = 3.
- Short yellow: NS 001 -> 010 x2 -> 100 -> err_valid one cycle after red sample, err_code = 4, err_sticky = 6'b001000, yellow_len_ns = 2.
- Conflict + walk: NS 001, EW 001, walk_ew = 1 in the same cycle -> err_code = 2, err_sticky = 6'b100010, err_count += 1.
- Skipped yellow: EW 001 -> 100 directly -> err_code = 3. Then EW green again after 1 all-red cycle -> err_code = 5.
- Bad encoding: lights_ns = 011 for 1 cycle -> err_code = 1. Returning to 001 afterwards -> no SEQ error.
- clear_err pulsed alongside a new WALK error -> err_sticky = 6'b100000, err_count = 1. Separately, force 65536 errors -> err_count stays 16'hFFFF.

Source files
------------

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor
//   Passive safety supervisor for the intersection controller outputs.
//   Every cycle it samples the NS/EW light codes and walk requests, tracks
//   a per-direction light state with a dwell timer plus a shared all-red
//   timer, and flags encoding, conflict, sequencing, yellow-length,
//   clearance and walk-safety violations one cycle after they are sampled.
//
// Ports
//   clk            clock
//   rst_n          synchronous active-low reset
//   lights_ns      NS light {RED,YELLOW,GREEN}, one-hot expected
//   lights_ew      EW light {RED,YELLOW,GREEN}, one-hot expected
//   walk_ns        NS walk signal
//   walk_ew        EW walk signal
//   clear_err      clears err_sticky and err_count on the next edge
//   err_valid      one-cycle pulse, violation seen in the previous sample
//   err_code       lowest-numbered violation code (1..6), valid with err_valid
//   err_sticky     bit n-1 set once code n has been seen since reset/clear
//   err_count      saturating count of err_valid pulses
//   yellow_len_ns  dwell of the last completed NS yellow phase
//   yellow_len_ew  dwell of the last completed EW yellow phase
module traffic_light_monitor #(
  parameter int MIN_YELLOW  = 3,
  parameter int MIN_ALL_RED = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       lights_ns,
  input  logic [2:0]       lights_ew,
  input  logic             walk_ns,
  input  logic             walk_ew,
  input  logic             clear_err,
  output logic             err_valid,
  output logic [2:0]       err_code,
  output logic [5:0]       err_sticky,
  output logic [15:0]      err_count,
  output logic [CNT_W-1:0] yellow_len_ns,
  output logic [CNT_W-1:0] yellow_len_ew
);

  typedef enum logic [1:0] {D_RED, D_YELLOW, D_GREEN, D_INVALID} dir_state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_YEL_C = CNT_W'(MIN_YELLOW);
  localparam logic [CNT_W-1:0] MIN_AR_C  = CNT_W'(MIN_ALL_RED);

  dir_state_t       ns_state, ew_state;
  dir_state_t       ns_cur, ew_cur;
  logic [CNT_W-1:0] ns_dwell, ew_dwell;
  logic [CNT_W-1:0] ns_dwell_next, ew_dwell_next;
  logic [CNT_W-1:0] all_red_cnt, all_red_next;
  logic [5:0]       flags;
  logic [2:0]       code_next;
  logic             any_err;

  function automatic dir_state_t decode(input logic [2:0] code);
    dir_state_t s;
    case (code)
      3'b100:  s = D_RED;
      3'b010:  s = D_YELLOW;
      3'b001:  s = D_GREEN;
      default: s = D_INVALID;
    endcase
    return s;
  endfunction

  // Illegal orderings between two valid colours; anything touching
  // D_INVALID is already covered by the encoding check.
  function automatic logic seq_bad(input dir_state_t prev, input dir_state_t cur);
    return (prev == D_GREEN  && cur == D_RED)   ||
           (prev == D_YELLOW && cur == D_GREEN) ||
           (prev == D_RED    && cur == D_YELLOW);
  endfunction

  function automatic logic [CNT_W-1:0] dwell_step(input dir_state_t prev,
                                                  input dir_state_t cur,
                                                  input logic [CNT_W-1:0] dwell);
    if (prev != cur)
      return CNT_ONE;
    else if (dwell == CNT_MAX)
      return dwell;
    else
      return dwell + CNT_ONE;
  endfunction

  // Next tracker state is simply the decoded sample; all checks compare the
  // current sample against the registered tracker state and timers.
  always_comb begin
    ns_cur        = decode(lights_ns);
    ew_cur        = decode(lights_ew);
    ns_dwell_next = dwell_step(ns_state, ns_cur, ns_dwell);
    ew_dwell_next = dwell_step(ew_state, ew_cur, ew_dwell);
    all_red_next  = '0;
    if (lights_ns == 3'b100 && lights_ew == 3'b100)
      all_red_next = (all_red_cnt == CNT_MAX) ? all_red_cnt : all_red_cnt + CNT_ONE;

    flags    = '0;
    flags[0] = (ns_cur == D_INVALID) || (ew_cur == D_INVALID);
    flags[1] = (|lights_ns[1:0]) && (|lights_ew[1:0]);
    flags[2] = seq_bad(ns_state, ns_cur) || seq_bad(ew_state, ew_cur);
    flags[3] = (ns_state == D_YELLOW && ns_cur == D_RED && ns_dwell < MIN_YEL_C) ||
               (ew_state == D_YELLOW && ew_cur == D_RED && ew_dwell < MIN_YEL_C);
    flags[4] = ((ns_state == D_RED && ns_cur == D_GREEN) ||
                (ew_state == D_RED && ew_cur == D_GREEN)) && (all_red_cnt < MIN_AR_C);
    flags[5] = (walk_ns && (lights_ns != 3'b001 || lights_ew != 3'b100)) ||
               (walk_ew && (lights_ew != 3'b001 || lights_ns != 3'b100));

    // Scan downwards so the lowest-numbered code is the one left standing.
    code_next = '0;
    for (int i = 5; i >= 0; i--)
      if (flags[i]) code_next = 3'(i + 1);
    any_err = |flags;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ns_state      <= D_RED;
      ew_state      <= D_RED;
      ns_dwell      <= '0;
      ew_dwell      <= '0;
      all_red_cnt   <= MIN_AR_C;
      err_valid     <= 1'b0;
      err_code      <= '0;
      err_sticky    <= '0;
      err_count     <= '0;
      yellow_len_ns <= '0;
      yellow_len_ew <= '0;
    end else begin
      ns_state    <= ns_cur;
      ew_state    <= ew_cur;
      ns_dwell    <= ns_dwell_next;
      ew_dwell    <= ew_dwell_next;
      all_red_cnt <= all_red_next;
      if (ns_state == D_YELLOW && ns_cur != D_YELLOW) yellow_len_ns <= ns_dwell;
      if (ew_state == D_YELLOW && ew_cur != D_YELLOW) yellow_len_ew <= ew_dwell;
      err_valid <= any_err;
      err_code  <= code_next;
      // A clear on the same edge as a fresh error keeps only the fresh error.
      if (clear_err) begin
        err_sticky <= flags;
        err_count  <= {15'b0, any_err};
      end else begin
        err_sticky <= err_sticky | flags;
        if (any_err && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor
//   Directed scenarios followed by random traffic, all compared against a
//   behavioural model that reasons about colour names, run lengths and
//   unbounded integer counters rather than registers.
module tb_traffic_light_monitor;

  localparam int MIN_YELLOW  = 3;
  localparam int MIN_ALL_RED = 2;
  localparam int CNT_W       = 8;
  localparam int DWELL_MAX   = 255;
  localparam int COUNT_MAX   = 65535;

  localparam int RED = 0, YEL = 1, GRN = 2, INV = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [2:0]       lights_ns, lights_ew;
  logic             walk_ns, walk_ew, clear_err;
  logic             err_valid;
  logic [2:0]       err_code;
  logic [5:0]       err_sticky;
  logic [15:0]      err_count;
  logic [CNT_W-1:0] yellow_len_ns, yellow_len_ew;

  int nChecks = 0;
  int nFail   = 0;

  // Reference model state
  int       mPrevN, mPrevE, mRunN, mRunE, mAllRed, mYelN, mYelE, mCount, mCode;
  bit [5:0] mSticky;
  bit       mValid;

  traffic_light_monitor #(
    .MIN_YELLOW(MIN_YELLOW), .MIN_ALL_RED(MIN_ALL_RED), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .lights_ns(lights_ns), .lights_ew(lights_ew),
    .walk_ns(walk_ns), .walk_ew(walk_ew), .clear_err(clear_err),
    .err_valid(err_valid), .err_code(err_code), .err_sticky(err_sticky),
    .err_count(err_count), .yellow_len_ns(yellow_len_ns), .yellow_len_ew(yellow_len_ew)
  );

  always #5 clk = ~clk;

  function automatic int colour(input logic [2:0] c);
    if (c == 3'b100) return RED;
    if (c == 3'b010) return YEL;
    if (c == 3'b001) return GRN;
    return INV;
  endfunction

  function automatic int capped(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic bit wrongOrder(input int p, input int c);
    return (p == GRN && c == RED) || (p == YEL && c == GRN) || (p == RED && c == YEL);
  endfunction

  task automatic modelReset();
    mPrevN = RED; mPrevE = RED; mRunN = 0; mRunE = 0; mAllRed = MIN_ALL_RED;
    mYelN = 0; mYelE = 0; mCount = 0; mCode = 0; mSticky = '0; mValid = 0;
  endtask

  task automatic modelStep(input logic [2:0] ns, input logic [2:0] ew,
                           input logic wn, input logic we, input logic clr);
    int cn, ce;
    bit [5:0] hit;
    cn = colour(ns);
    ce = colour(ew);
    hit    = '0;
    hit[0] = (cn == INV) || (ce == INV);
    hit[1] = ((ns & 3'b011) != 0) && ((ew & 3'b011) != 0);
    hit[2] = wrongOrder(mPrevN, cn) || wrongOrder(mPrevE, ce);
    hit[3] = (mPrevN == YEL && cn == RED && capped(mRunN, DWELL_MAX) < MIN_YELLOW) ||
             (mPrevE == YEL && ce == RED && capped(mRunE, DWELL_MAX) < MIN_YELLOW);
    hit[4] = ((mPrevN == RED && cn == GRN) || (mPrevE == RED && ce == GRN)) &&
             (capped(mAllRed, DWELL_MAX) < MIN_ALL_RED);
    hit[5] = (wn && (ns != 3'b001 || ew != 3'b100)) || (we && (ew != 3'b001 || ns != 3'b100));
    mValid = (hit != 0);
    mCode  = 0;
    for (int i = 5; i >= 0; i--) if (hit[i]) mCode = i + 1;
    if (clr) begin
      mSticky = hit;
      mCount  = mValid ? 1 : 0;
    end else begin
      mSticky = mSticky | hit;
      mCount  = mCount + (mValid ? 1 : 0);
    end
    if (mPrevN == YEL && cn != YEL) mYelN = capped(mRunN, DWELL_MAX);
    if (mPrevE == YEL && ce != YEL) mYelE = capped(mRunE, DWELL_MAX);
    mRunN   = (cn == mPrevN) ? mRunN + 1 : 1;
    mRunE   = (ce == mPrevE) ? mRunE + 1 : 1;
    mAllRed = (ns == 3'b100 && ew == 3'b100) ? mAllRed + 1 : 0;
    mPrevN  = cn;
    mPrevE  = ce;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    checkOutput("err_valid", 32'(err_valid), 32'(mValid));
    if (mValid) checkOutput("err_code", 32'(err_code), 32'(mCode));
    checkOutput("err_sticky", 32'(err_sticky), 32'(mSticky));
    checkOutput("err_count", 32'(err_count), 32'(capped(mCount, COUNT_MAX)));
    checkOutput("yellow_len_ns", 32'(yellow_len_ns), 32'(mYelN));
    checkOutput("yellow_len_ew", 32'(yellow_len_ew), 32'(mYelE));
  endtask

  // Drive one sample, let it be clocked in, advance the model, then look at
  // the outputs 1 time unit after the edge.
  task automatic applyStimulus(input logic [2:0] ns, input logic [2:0] ew,
                               input logic wn = 1'b0, input logic we = 1'b0,
                               input logic clr = 1'b0, input logic rstn = 1'b1,
                               input bit doCheck = 1'b1);
    lights_ns = ns; lights_ew = ew; walk_ns = wn; walk_ew = we;
    clear_err = clr; rst_n = rstn;
    @(posedge clk);
    if (!rstn) modelReset();
    else       modelStep(ns, ew, wn, we, clr);
    #1;
    if (doCheck) checkAll();
  endtask

  task automatic resetDut();
    applyStimulus(3'b100, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'b100, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [2:0] legal [3];
    logic [2:0] rn, re;
    legal[0] = 3'b100; legal[1] = 3'b010; legal[2] = 3'b001;
    lights_ns = 3'b100; lights_ew = 3'b100; walk_ns = 0; walk_ew = 0;
    clear_err = 0; rst_n = 0;
    modelReset();

    // Reset values
    resetDut();
    checkOutput("rst_valid", 32'(err_valid), 32'd0);
    checkOutput("rst_sticky", 32'(err_sticky), 32'd0);
    checkOutput("rst_count", 32'(err_count), 32'd0);
    checkOutput("rst_yel_ns", 32'(yellow_len_ns), 32'd0);

    // Legal cycle, green straight after reset is allowed
    for (int i = 0; i < 10; i++) applyStimulus(3'b001, 3'b100);
    for (int i = 0; i < 3; i++)  applyStimulus(3'b010, 3'b100);
    applyStimulus(3'b100, 3'b100);
    applyStimulus(3'b100, 3'b100);
    applyStimulus(3'b100, 3'b001);
    checkOutput("legal_valid", 32'(err_valid), 32'd0);
    checkOutput("legal_count", 32'(err_count), 32'd0);
    checkOutput("legal_yel_ns", 32'(yellow_len_ns), 32'd3);

    // Short yellow
    resetDut();
    applyStimulus(3'b001, 3'b100);
    applyStimulus(3'b010, 3'b100);
    applyStimulus(3'b010, 3'b100);
    applyStimulus(3'b100, 3'b100);
    checkOutput("short_valid", 32'(err_valid), 32'd1);
    checkOutput("short_code", 32'(err_code), 32'd4);
    checkOutput("short_sticky", 32'(err_sticky), 32'b001000);
    checkOutput("short_yel_ns", 32'(yellow_len_ns), 32'd2);
    applyStimulus(3'b100, 3'b100);
    checkOutput("short_pulse_end", 32'(err_valid), 32'd0);

    // Conflict plus walk in the same sample
    resetDut();
    applyStimulus(3'b001, 3'b001, 1'b0, 1'b1);
    checkOutput("conf_code", 32'(err_code), 32'd2);
    checkOutput("conf_sticky", 32'(err_sticky), 32'b100010);
    checkOutput("conf_count", 32'(err_count), 32'd1);

    // Skipped yellow, then green after a single all-red sample
    resetDut();
    applyStimulus(3'b100, 3'b001);
    applyStimulus(3'b100, 3'b100);
    checkOutput("skip_code", 32'(err_code), 32'd3);
    applyStimulus(3'b100, 3'b001);
    checkOutput("clear_code", 32'(err_code), 32'd5);
    checkOutput("clear_sticky", 32'(err_sticky), 32'b010100);

    // Bad encoding and recovery without a sequence error
    resetDut();
    applyStimulus(3'b001, 3'b100);
    applyStimulus(3'b011, 3'b100);
    checkOutput("enc_code", 32'(err_code), 32'd1);
    applyStimulus(3'b001, 3'b100);
    checkOutput("enc_recover", 32'(err_valid), 32'd0);

    // Walk errors, then clear together with a new walk error
    applyStimulus(3'b001, 3'b100, 1'b0, 1'b1);
    applyStimulus(3'b001, 3'b100, 1'b0, 1'b1);
    checkOutput("walk_count", 32'(err_count), 32'd3);
    applyStimulus(3'b001, 3'b100, 1'b0, 1'b1, 1'b1);
    checkOutput("clr_sticky", 32'(err_sticky), 32'b100000);
    checkOutput("clr_count", 32'(err_count), 32'd1);

    // Saturated yellow dwell still counts as long enough
    resetDut();
    applyStimulus(3'b001, 3'b100);
    for (int i = 0; i < 300; i++) applyStimulus(3'b010, 3'b100);
    applyStimulus(3'b100, 3'b100);
    checkOutput("dwell_sat_valid", 32'(err_valid), 32'd0);
    checkOutput("dwell_sat_len", 32'(yellow_len_ns), 32'd255);

    // Random traffic with occasional clear and reset
    resetDut();
    for (int i = 0; i < 600; i++) begin
      rn = ($urandom_range(0, 9) < 8) ? legal[$urandom_range(0, 2)] : 3'($urandom_range(0, 7));
      re = ($urandom_range(0, 9) < 8) ? legal[$urandom_range(0, 2)] : 3'($urandom_range(0, 7));
      applyStimulus(rn, re, 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0),
                    1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 59) != 0));
    end

    // Error count saturation
    resetDut();
    for (int i = 0; i < 65540; i++)
      applyStimulus(3'b000, 3'b100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkAll();
    checkOutput("count_sat", 32'(err_count), 32'hFFFF);
    checkOutput("count_sat_sticky", 32'(err_sticky), 32'b000001);
    applyStimulus(3'b100, 3'b100, 1'b0, 1'b0, 1'b1);
    checkOutput("count_cleared", 32'(err_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
